cmp_sorter4: RTL and testbench
==============================

# cmp_sorter4

Sequential 4-entry sorter built around a single shared instance of the team's 4-bit `comparator` (p, q → EQL, LTR). It accepts four 4-bit values over a valid/ready stream and bubble-sorts them in place, issuing one comparison per clock through the comparator. It then streams the sorted values out over a second valid/ready port. It is the sequencing controller that time-shares the comparator datapath.

## Interface
- `DESCEND`, default 0: 0 sorts ascending (smallest first); 1 sorts descending.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `in_data` is valid this cycle.
- `in_data`  input  4  value to load.
- `in_ready`  output  1  high while in LOAD; a beat is accepted on `in_valid && in_ready`.
- `out_valid`  output  1  high while in DRAIN; `out_data` is valid.
- `out_data`  output  4  current sorted value.
- `out_ready`  input  1  consumer accepts on `out_valid && out_ready`.
- `busy`  output  1  high in SORT.
- `cmp_cnt`  output  3  number of comparator operations in the current or most recent sort.

## Operation
- Storage: `buf[0..3]` (4 bits each), write pointer `wr` (2 bits), read pointer `rd` (2 bits), pass counter `pass` (0..2), index `idx` (0..2-pass), and flag `swapped`.
- **LOAD**
  - `in_ready=1`. Each accepted beat writes `buf[wr]` and increments `wr`.
  - The 4th accept (wr==3) sets `pass=0`, `idx=0`, `swapped=0`, `cmp_cnt=0`, and moves to SORT.
- **SORT**
  - Each cycle, comparator inputs are `p=buf[idx+1]`, `q=buf[idx]` (DESCEND=0), or `p=buf[idx]`, `q=buf[idx+1]` (DESCEND=1). Inputs are combinational muxes from `buf`.
  - If LTR=1, swap `buf[idx]` and `buf[idx+1]` at the clock edge and set `swapped`. EQL=1 never swaps, so equal keys keep input order (stable).
  - `cmp_cnt` increments every SORT cycle.
  - End of pass (idx==2-pass): `pass++`, `idx=0`, clear `swapped`. After pass 2 completes, move to DRAIN with `rd=0`.
- **DRAIN**
  - `out_valid=1`, `out_data=buf[rd]`. Each handshake increments `rd`.
  - The handshake at rd==3 moves to LOAD with `wr=0`.
- `in_valid` is ignored outside LOAD. `out_ready` is ignored outside DRAIN.
- Comparator interpretation: LTR=1 means p<q, EQL=1 means p==q. The block relies only on LTR for swap decisions.

## Timing
- Reset (async, while `rst_n=0`):
  - state=LOAD, so `in_ready=1`.
  - `out_valid=0`, `out_data=0`, `busy=0`, `cmp_cnt=0`.
  - `buf`, `wr`, `rd`, `pass`, `idx`, `swapped` are all cleared.
- Reset asserted mid-SORT or mid-DRAIN discards all data. The first cycle after release is LOAD.
- Latency: 4th input accepted at edge T. SORT occupies T+1..T+6 (6 compares, passes of 3/2/1). `out_valid` rises after edge T+6.
  - With early exit (see Configuration), SORT can be as short as 3 cycles.
- `out_data` and `out_valid` are driven from registered state and `buf`; they are stable while stalled (`out_ready=0`).
- Back-to-back: LOAD is entered on the final drain edge, so `in_ready=1` the next cycle with no bubble.
- `cmp_cnt` holds its final value through DRAIN and the following LOAD, until the next SORT entry.

## Configuration
- `CMP_SORTER_EARLY_EXIT_EN` defined: at the end of any pass with `swapped==0` (including the swap decision of the pass's last compare), go straight to DRAIN. Already-sorted input takes 3 SORT cycles, `cmp_cnt=3`.
- Undefined: always run all 3 passes, 6 SORT cycles, `cmp_cnt=6`, regardless of data.

## Test plan
- Load 9,3,12,1 (DESCEND=0), `out_ready=1` → outputs 1,3,9,12; `busy` high exactly 6 cycles; `cmp_cnt=6`.
- Load 2,5,7,15 with early exit defined → `cmp_cnt=3`, `busy` 3 cycles, outputs 2,5,7,15. Without the macro → `cmp_cnt=6`, same outputs.
- DESCEND=1, load 4,4,0,15 → outputs 15,4,4,0. Tag check by forcing the probe order shows the two 4s keep input order.
- Drain 8,6,7,5 with `out_ready` toggling 1,0,0,1,... → `out_data` held during stalls; sequence 5,6,7,8; `in_ready` rises the cycle after the 4th handshake.
- Assert `rst_n=0` on the 3rd SORT cycle of 15,14,13,12 → `busy=0`, `out_valid=0`, `cmp_cnt=0`, `in_ready=1` immediately. Next load of 1,0,0,0 outputs 0,0,0,1.
- Hold `in_valid=1` with 3 during SORT and DRAIN → no corruption; only 4 loads are accepted per cycle set.

Source files
------------

// File: rtl/cmp_sorter4.sv
// cmp_sorter4: loads four 4-bit values, bubble-sorts them in place with one shared comparator, then streams them out.
// Optional build macro CMP_SORTER_EARLY_EXIT_EN leaves SORT after any pass that made no swaps.

module comparator (
  input  logic [3:0] p,
  input  logic [3:0] q,
  output logic       eql,
  output logic       ltr
);
  assign eql = (p == q);
  assign ltr = (p < q);
endmodule

module cmp_sorter4 #(
  parameter bit DESCEND = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic [2:0] cmp_cnt
);
  typedef enum logic [1:0] {ST_LOAD, ST_SORT, ST_DRAIN} state_t;

  state_t     state_q, state_d;
  logic [3:0] buf_q [4];
  logic [3:0] buf_d [4];
  logic [1:0] wr_q, wr_d;
  logic [1:0] rd_q, rd_d;
  logic [1:0] pass_q, pass_d;
  logic [1:0] idx_q, idx_d;
  logic       swapped_q, swapped_d;
  logic [2:0] cmp_cnt_q, cmp_cnt_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       busy_q, busy_d;
  logic [3:0] out_data_q, out_data_d;

  logic [1:0] idx_nx;
  logic [3:0] lo_val, hi_val, cmp_p, cmp_q;
  logic       cmp_eql, cmp_ltr;
  logic       load_fire, drain_fire, do_swap, pass_end, sort_done, swapped_now;

  assign idx_nx = idx_q + 2'd1;
  assign lo_val = buf_q[idx_q];
  assign hi_val = buf_q[idx_nx];
  assign cmp_p  = DESCEND ? lo_val : hi_val;
  assign cmp_q  = DESCEND ? hi_val : lo_val;

  comparator u_cmp (
    .p   (cmp_p),
    .q   (cmp_q),
    .eql (cmp_eql),
    .ltr (cmp_ltr)
  );

  assign load_fire   = (state_q == ST_LOAD) && in_valid;
  assign drain_fire  = (state_q == ST_DRAIN) && out_ready;
  // Equal keys never swap, which keeps the sort stable.
  assign do_swap     = (state_q == ST_SORT) && cmp_ltr && !cmp_eql;
  assign swapped_now = swapped_q || do_swap;
  assign pass_end    = (idx_q == (2'd2 - pass_q));
`ifdef CMP_SORTER_EARLY_EXIT_EN
  assign sort_done   = (pass_q == 2'd2) || !swapped_now;
`else
  assign sort_done   = (pass_q == 2'd2);
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_buf
    assign buf_d[gi] = (load_fire && wr_q == 2'(gi))  ? in_data :
                       (do_swap && idx_q == 2'(gi))   ? hi_val  :
                       (do_swap && idx_nx == 2'(gi))  ? lo_val  :
                                                        buf_q[gi];
  end

  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    pass_d    = pass_q;
    idx_d     = idx_q;
    swapped_d = swapped_q;
    cmp_cnt_d = cmp_cnt_q;
    unique case (state_q)
      ST_LOAD: begin
        if (load_fire) begin
          wr_d = wr_q + 2'd1;
          if (wr_q == 2'd3) begin
            state_d   = ST_SORT;
            pass_d    = 2'd0;
            idx_d     = 2'd0;
            swapped_d = 1'b0;
            cmp_cnt_d = 3'd0;
          end
        end
      end
      ST_SORT: begin
        cmp_cnt_d = cmp_cnt_q + 3'd1;
        if (pass_end) begin
          idx_d     = 2'd0;
          swapped_d = 1'b0;
          if (sort_done) begin
            state_d = ST_DRAIN;
            rd_d    = 2'd0;
          end else begin
            pass_d = pass_q + 2'd1;
          end
        end else begin
          idx_d     = idx_nx;
          swapped_d = swapped_now;
        end
      end
      ST_DRAIN: begin
        if (drain_fire) begin
          rd_d = rd_q + 2'd1;
          if (rd_q == 2'd3) begin
            state_d = ST_LOAD;
            wr_d    = 2'd0;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state they describe.
  always_comb begin
    in_ready_d  = (state_d == ST_LOAD);
    out_valid_d = (state_d == ST_DRAIN);
    busy_d      = (state_d == ST_SORT);
    out_data_d  = (state_d == ST_DRAIN) ? buf_d[rd_d] : 4'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_LOAD;
      wr_q        <= 2'd0;
      rd_q        <= 2'd0;
      pass_q      <= 2'd0;
      idx_q       <= 2'd0;
      swapped_q   <= 1'b0;
      cmp_cnt_q   <= 3'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= 4'd0;
      for (int i = 0; i < 4; i++) buf_q[i] <= 4'd0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      pass_q      <= pass_d;
      idx_q       <= idx_d;
      swapped_q   <= swapped_d;
      cmp_cnt_q   <= cmp_cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      for (int i = 0; i < 4; i++) buf_q[i] <= buf_d[i];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign cmp_cnt   = cmp_cnt_q;
endmodule

// File: tb/tb_cmp_sorter4.sv
// Scoreboard bench for cmp_sorter4: one ascending and one descending instance, directed vectors.
module tb_cmp_sorter4;
  typedef struct {
    int         k;
    logic [3:0] d;
    logic [2:0] cnt;
    bit         last;
  } exp_t;

`ifdef CMP_SORTER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid  [2];
  logic [3:0] in_data   [2];
  logic       in_ready  [2];
  logic       out_valid [2];
  logic [3:0] out_data  [2];
  logic       out_ready [2];
  logic       busy      [2];
  logic [2:0] cmp_cnt   [2];

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   busy_cyc = 0;
  int   acc_cnt = 0;
  bit   toggle_en = 1'b0;
  int   ph = 0;
  bit   chk_idle [2];

  always #5 clk = ~clk;

  cmp_sorter4 #(.DESCEND(1'b0)) u_asc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]),
    .busy(busy[0]), .cmp_cnt(cmp_cnt[0])
  );

  cmp_sorter4 #(.DESCEND(1'b1)) u_desc (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]),
    .busy(busy[1]), .cmp_cnt(cmp_cnt[1])
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Consumer handshake pattern 1,0,0,1,0,0,... when toggling is enabled.
  always @(posedge clk) begin
    #1;
    if (toggle_en) begin
      out_ready[0] = (ph % 3 == 0);
      ph++;
    end else begin
      out_ready[0] = 1'b1;
      ph = 0;
    end
    out_ready[1] = 1'b1;
  end

  // Monitor: pops the scoreboard on every output handshake; also counts busy cycles and accepts.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        busy_cyc += int'(busy[k]);
        acc_cnt  += int'(in_valid[k] && in_ready[k]);
        if (chk_idle[k]) begin
          chk_idle[k] = 1'b0;
          check("in_ready_after_drain", int'(in_ready[k]), 1);
          check("out_valid_after_drain", int'(out_valid[k]), 0);
        end
        if (out_valid[k]) begin
          if (sb.size() == 0) begin
            check("output_expected", sb.size(), 1);
          end else if (out_ready[k]) begin
            e = sb.pop_front();
            $display("out dut=%0d data=%0d cmp_cnt=%0d (exp dut=%0d data=%0d cnt=%0d)",
                     k, out_data[k], cmp_cnt[k], e.k, e.d, e.cnt);
            check("out_dut", k, e.k);
            check("out_data", int'(out_data[k]), int'(e.d));
            check("out_cmp_cnt", int'(cmp_cnt[k]), int'(e.cnt));
            if (e.last) chk_idle[k] = 1'b1;
          end else begin
            check("stall_hold", int'(out_data[k]), int'(sb[0].d));
          end
        end
      end
    end
  end

  task automatic send(input int k, input logic [3:0] v);
    int w = 0;
    in_valid[k] = 1'b1;
    in_data[k]  = v;
    while (!in_ready[k] && w < 100) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 100) check("send_timeout", w, 0);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    $display("in dut=%0d data=%0d", k, v);
  endtask

  task automatic wait_drain(input int k);
    int w = 0;
    @(negedge clk);
    while (!(sb.size() == 0 && in_ready[k] && !out_valid[k]) && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("drain_done", int'(w < 300), 1);
  endtask

  task automatic push_set(input int k, input logic [3:0] vout [4], input int cnt);
    for (int i = 0; i < 4; i++) sb.push_back('{k, vout[i], 3'(cnt), (i == 3)});
  endtask

  task automatic run_set(input int k, input logic [3:0] vin [4], input logic [3:0] vout [4],
                         input int cnt, input string tag);
    int b0;
    b0 = busy_cyc;
    push_set(k, vout, cnt);
    for (int i = 0; i < 4; i++) send(k, vin[i]);
    wait_drain(k);
    check({tag, "_busy_cycles"}, busy_cyc - b0, cnt);
    check({tag, "_cmp_cnt"}, int'(cmp_cnt[k]), cnt);
  endtask

  initial begin
    int a0, b0, w;
    in_valid = '{1'b0, 1'b0};
    in_data  = '{4'd0, 4'd0};
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_in_ready", int'(in_ready[k]), 1);
      check("rst_out_valid", int'(out_valid[k]), 0);
      check("rst_out_data", int'(out_data[k]), 0);
      check("rst_busy", int'(busy[k]), 0);
      check("rst_cmp_cnt", int'(cmp_cnt[k]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_set(0, '{4'd9, 4'd3, 4'd12, 4'd1}, '{4'd1, 4'd3, 4'd9, 4'd12}, 6, "asc_9_3_12_1");
    run_set(0, '{4'd2, 4'd5, 4'd7, 4'd15}, '{4'd2, 4'd5, 4'd7, 4'd15}, EE ? 3 : 6, "sorted");
    run_set(1, '{4'd4, 4'd4, 4'd0, 4'd15}, '{4'd15, 4'd4, 4'd4, 4'd0}, 6, "desc");

    toggle_en = 1'b1;
    run_set(0, '{4'd8, 4'd6, 4'd7, 4'd5}, '{4'd5, 4'd6, 4'd7, 4'd8}, 6, "stall");
    toggle_en = 1'b0;

    // Reset during the third SORT cycle.
    send(0, 4'd15); send(0, 4'd14); send(0, 4'd13); send(0, 4'd12);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_reset_busy", int'(busy[0]), 1);
    rst_n = 1'b0;
    #1;
    check("midsort_rst_busy", int'(busy[0]), 0);
    check("midsort_rst_out_valid", int'(out_valid[0]), 0);
    check("midsort_rst_cmp_cnt", int'(cmp_cnt[0]), 0);
    check("midsort_rst_in_ready", int'(in_ready[0]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    run_set(0, '{4'd1, 4'd0, 4'd0, 4'd0}, '{4'd0, 4'd0, 4'd0, 4'd1}, EE ? 5 : 6, "after_rst");

    // in_valid held high with 3 through SORT and DRAIN: exactly one extra set of four 3s loads.
    a0 = acc_cnt;
    b0 = busy_cyc;
    push_set(0, '{4'd2, 4'd4, 4'd6, 4'd10}, 6);
    push_set(0, '{4'd3, 4'd3, 4'd3, 4'd3}, EE ? 3 : 6);
    send(0, 4'd10); send(0, 4'd2); send(0, 4'd6); send(0, 4'd4);
    in_valid[0] = 1'b1;
    in_data[0]  = 4'd3;
    w = 0;
    while (acc_cnt - a0 < 8 && w < 400) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_drain(0);
    check("hold_accepts", acc_cnt - a0, 8);
    check("hold_busy_cycles", busy_cyc - b0, 6 + (EE ? 3 : 6));
    check("hold_cmp_cnt", int'(cmp_cnt[0]), EE ? 3 : 6);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
